sr_button_debouncer: RTL and testbench



---
 rtl/sr_pkg.sv | 16 +
 rtl/debounce_channel.sv | 115 +++++++++++
 rtl/sr_button_debouncer.sv | 66 ++++++
 tb/tb_sr_button_debouncer.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// Shared definitions for the set/reset button debouncer.
// Channel FSM state encoding and the default qualification length.
package sr_pkg;

    // Per-channel debounce FSM states
    typedef enum logic [1:0] {
        LOW  = 2'd0,
        RISE = 2'd1,
        HIGH = 2'd2,
        FALL = 2'd3
    } deb_state_e;

    // Default number of stable synchronised samples to qualify a change
    localparam int DEF_DEBOUNCE_CYCLES = 16;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, stability counter, FSM.
// Produces the debounced level and a one-cycle rising-edge request.
module debounce_channel
    import sr_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_req
);

    localparam logic [CNT_W-1:0] C_TARGET = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    deb_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_req;

    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_done;

    // Saturating increment; the count is zero whenever the FSM is settled,
    // so the same increment also yields the first sample from LOW/HIGH.
    always_comb begin
        w_cnt_inc = (r_cnt == C_TARGET) ? r_cnt : r_cnt + C_ONE;
        w_done    = (w_cnt_inc == C_TARGET);
    end

    // Synchroniser plus debounce FSM with registered level and request
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_state <= LOW;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_req   <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_req   <= 1'b0;
            unique case (r_state)
                LOW: begin
                    if (r_sync2) begin
                        if (w_done) begin
                            r_state <= HIGH;
                            r_level <= 1'b1;
                            r_req   <= 1'b1;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= RISE;
                            r_cnt   <= w_cnt_inc;
                        end
                    end
                end
                RISE: begin
                    if (r_sync2) begin
                        if (w_done) begin
                            r_state <= HIGH;
                            r_level <= 1'b1;
                            r_req   <= 1'b1;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end else begin
                        r_state <= LOW;
                        r_cnt   <= '0;
                    end
                end
                HIGH: begin
                    if (!r_sync2) begin
                        if (w_done) begin
                            r_state <= LOW;
                            r_level <= 1'b0;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= FALL;
                            r_cnt   <= w_cnt_inc;
                        end
                    end
                end
                FALL: begin
                    if (!r_sync2) begin
                        if (w_done) begin
                            r_state <= LOW;
                            r_level <= 1'b0;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end else begin
                        r_state <= HIGH;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= LOW;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_level = r_level;
    assign o_req   = r_req;

endmodule

// File: rtl/sr_button_debouncer.sv
// Two debounced push-button channels feeding clean S/R pulses to a latch.
// Define SR_DEBOUNCE_RESET_PRIORITY_EN to let reset win simultaneous requests.
module sr_button_debouncer
    import sr_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_s,
    input  logic btn_r,
    output logic S,
    output logic R,
    output logic s_level,
    output logic r_level,
    output logic conflict
);

    logic w_req_s;
    logic w_req_r;
    logic r_s;
    logic r_r;
    logic r_conflict;

    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan_s (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_s),
        .o_level (s_level),
        .o_req   (w_req_s)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan_r (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_r),
        .o_level (r_level),
        .o_req   (w_req_r)
    );

    // Registered arbitration so the latch never sees S and R together
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s        <= 1'b0;
            r_r        <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_s        <= w_req_s & ~w_req_r;
`ifdef SR_DEBOUNCE_RESET_PRIORITY_EN
            r_r        <= w_req_r;
`else
            r_r        <= w_req_r & ~w_req_s;
`endif
            r_conflict <= w_req_s & w_req_r;
        end
    end

    assign S        = r_s;
    assign R        = r_r;
    assign conflict = r_conflict;

endmodule

// File: tb/tb_sr_button_debouncer.sv
// Directed bench for sr_button_debouncer (DEBOUNCE_CYCLES=4 and =1).
// Edge k is the k-th rising edge after the stimulus is applied.
module tb_sr_button_debouncer;

    logic clk = 1'b0;
    logic rst;
    logic btn_s, btn_r;
    logic S, R, s_level, r_level, conflict;
    logic btn1_s, btn1_r;
    logic S1, R1, s1_level, r1_level, conflict1;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sr_button_debouncer #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .btn_s(btn_s), .btn_r(btn_r),
        .S(S), .R(R), .s_level(s_level), .r_level(r_level),
        .conflict(conflict)
    );

    sr_button_debouncer #(.DEBOUNCE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .btn_s(btn1_s), .btn_r(btn1_r),
        .S(S1), .R(R1), .s_level(s1_level), .r_level(r1_level),
        .conflict(conflict1)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check4(input string tag, input logic es, input logic er,
                          input logic esl, input logic erl, input logic ec);
        check({tag, ".S"}, S, es);
        check({tag, ".R"}, R, er);
        check({tag, ".s_level"}, s_level, esl);
        check({tag, ".r_level"}, r_level, erl);
        check({tag, ".conflict"}, conflict, ec);
    endtask

    task automatic do_reset();
        btn_s = 0; btn_r = 0; btn1_s = 0; btn1_r = 0;
        rst = 1;
        step();
        check4("reset", 0, 0, 0, 0, 0);
        rst = 0;
    endtask

    initial begin
        logic exp_r4;
        rst = 1; btn_s = 0; btn_r = 0; btn1_s = 0; btn1_r = 0;

        // Reset held for two cycles
        step();
        check4("rst0", 0, 0, 0, 0, 0);
        step();
        check4("rst1", 0, 0, 0, 0, 0);

        // 1: btn_s held -> S at edge 6, level at edge 5
        rst = 0; btn_s = 1;
        for (int k = 0; k < 10; k++) begin
            step();
            check4($sformatf("t1.e%0d", k), k == 6, 0, k >= 5, 0, 0);
        end

        // 2: btn_r bounces 1,0,1,0 then held from edge 4
        do_reset();
        for (int k = 0; k < 14; k++) begin
            btn_r = (k < 4) ? ((k % 2) == 0) : 1'b1;
            step();
            check4($sformatf("t2.e%0d", k), 0, k == 10, 0, k >= 9, 0);
        end

        // 3: held 20 cycles, released 10; no pulse on release
        do_reset();
        for (int k = 0; k < 30; k++) begin
            btn_s = (k < 20);
            step();
            check4($sformatf("t3.e%0d", k), k == 6, 0,
                   (k >= 5) && (k < 25), 0, 0);
        end

        // 4: simultaneous rise on both buttons
        do_reset();
        btn_s = 1; btn_r = 1;
`ifdef SR_DEBOUNCE_RESET_PRIORITY_EN
        exp_r4 = 1'b1;
`else
        exp_r4 = 1'b0;
`endif
        for (int k = 0; k < 10; k++) begin
            step();
            check4($sformatf("t4.e%0d", k), 0, exp_r4 && (k == 6),
                   k >= 5, k >= 5, k == 6);
        end

        // 5: reset at cnt=3 discards the partial count
        do_reset();
        btn_s = 1;
        for (int k = 0; k < 5; k++) begin
            step();
            check4($sformatf("t5a.e%0d", k), 0, 0, 0, 0, 0);
        end
        rst = 1;
        step();
        check4("t5.rst", 0, 0, 0, 0, 0);
        rst = 0;
        for (int k = 0; k < 9; k++) begin
            step();
            check4($sformatf("t5b.e%0d", k), k == 6, 0, k >= 5, 0, 0);
        end

        // 6: DEBOUNCE_CYCLES=1, single-cycle btn pulse
        do_reset();
        btn1_s = 1;
        for (int k = 0; k < 7; k++) begin
            step();
            btn1_s = 0;
            check($sformatf("t6.e%0d.S", k), S1, k == 3);
            check($sformatf("t6.e%0d.R", k), R1, 1'b0);
            check($sformatf("t6.e%0d.lvl", k), s1_level, k == 2);
            check($sformatf("t6.e%0d.cf", k), conflict1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
